bus_gate_arbiter: RTL and testbench

Round-robin arbiter that shares the CPU's single gated bus line among up to four requesters. Each registered one-hot grant bit drives one input of a quad 2-input AND gate (74x08), whose other input is the requester's strobe. The gate output therefore reaches the shared line only for the current owner. The block enforces a turnaround gap between owners and an optional maximum hold time, so the discrete-logic bus never sees two drivers.

---
 rtl/bus_gate_pkg.sv | 10 +
 rtl/rr_pick.sv | 27 ++
 rtl/bus_gate_arbiter.sv | 100 ++++++++++
 tb/tb_bus_gate_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/bus_gate_pkg.sv
// bus_gate_pkg: shared state encoding, default parameters and width helper for the bus gate arbiter
package bus_gate_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
    localparam int N_REQ_DEF = 4;
    localparam int MAX_HOLD_DEF = 16;
    localparam int TURNAROUND_DEF = 1;
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr with wrap
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] win_oh,
    output logic [W-1:0] win_idx,
    output logic         found
);
    logic [W-1:0] j;
    always_comb begin
        win_oh = '0;
        win_idx = '0;
        found = 1'b0;
        j = '0;
        for (int i = 0; i < N; i++) begin
            j = W'((int'(ptr) + i) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                win_oh[j] = 1'b1;
                win_idx = j;
            end
        end
    end
endmodule

// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter: round-robin owner of the gated bus line with turnaround gap and hold limit
module bus_gate_arbiter
    import bus_gate_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int TURNAROUND = TURNAROUND_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic                       timeout
);
    localparam int OW = idx_w(N_REQ);
    localparam int HW = idx_w(MAX_HOLD + 1);
    localparam int TW = idx_w(TURNAROUND + 1);

    state_t state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d, pick_oh;
    logic [OW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] turn_q, turn_d;
    logic busy_q, busy_d, timeout_q, timeout_d, pick_any, arb;

    rr_pick #(.N(N_REQ), .W(OW)) u_pick (
        .req(req),
        .ptr(ptr_q),
        .win_oh(pick_oh),
        .win_idx(pick_idx),
        .found(pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        hold_d = '0;
        turn_d = '0;
        grant_d = '0;
        owner_d = owner_q;
        timeout_d = 1'b0;
        arb = (state_q == IDLE) || (state_q == TURN && turn_q == TW'(TURNAROUND));
        if (state_q == GRANT) begin
            grant_d = grant_q;
            hold_d = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
            if (!req[owner_q]) begin
                state_d = TURN;
                grant_d = '0;
                hold_d = '0;
                turn_d = TW'(1);
            end else if (MAX_HOLD != 0 && hold_q == HW'(MAX_HOLD) && |(req & ~grant_q)) begin
                state_d = TURN;
                grant_d = '0;
                hold_d = '0;
                turn_d = TW'(1);
                timeout_d = 1'b1;
            end
        end else if (arb) begin
            state_d = pick_any ? GRANT : IDLE;
            if (pick_any) begin
                grant_d = pick_oh;
                owner_d = pick_idx;
                ptr_d = (pick_idx == OW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                hold_d = HW'(MAX_HOLD != 0);
            end
        end else begin
            turn_d = turn_q + 1'b1;
        end
        busy_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            hold_q <= '0;
            turn_q <= '0;
            grant_q <= '0;
            owner_q <= '0;
            busy_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            hold_q <= hold_d;
            turn_q <= turn_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            busy_q <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy = busy_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_bus_gate_arbiter.sv
// tb_bus_gate_arbiter: scoreboard bench over four parameterisations of the arbiter
module tb_bus_gate_arbiter;
    typedef struct {
        int d;
        logic [3:0] g;
        logic [1:0] o;
        logic t;
        string nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req_v [4];
    logic [3:0] g [4];
    logic [1:0] o [4];
    logic b [4];
    logic t [4];
    exp_t q[$];
    int sel = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bus_gate_arbiter u0 (.clk(clk), .rst(rst), .req(req_v[0]), .grant(g[0]), .owner(o[0]), .busy(b[0]), .timeout(t[0]));
    bus_gate_arbiter #(.MAX_HOLD(0)) u1 (.clk(clk), .rst(rst), .req(req_v[1]), .grant(g[1]), .owner(o[1]), .busy(b[1]), .timeout(t[1]));
    bus_gate_arbiter #(.MAX_HOLD(4)) u2 (.clk(clk), .rst(rst), .req(req_v[2]), .grant(g[2]), .owner(o[2]), .busy(b[2]), .timeout(t[2]));
    bus_gate_arbiter #(.TURNAROUND(3)) u3 (.clk(clk), .rst(rst), .req(req_v[3]), .grant(g[3]), .owner(o[3]), .busy(b[3]), .timeout(t[3]));

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            total++;
            if ({g[e.d], o[e.d], b[e.d], t[e.d]} !== {e.g, e.o, |e.g, e.t}) begin
                bad++;
                $display("FAIL %s dut%0d: got g=%b o=%0d b=%b t=%b want g=%b o=%0d b=%b t=%b",
                         e.nm, e.d, g[e.d], o[e.d], b[e.d], t[e.d], e.g, e.o, |e.g, e.t);
            end
        end
    end

    task automatic cyc(input logic [3:0] r, input logic [3:0] gx, input int ox, input logic tx, input string nm);
        req_v[sel] = r;
        q.push_back('{sel, gx, 2'(ox), tx, nm});
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_v[i] = 4'h0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = i;
            cyc(4'h0, 4'h0, 0, 0, "reset");
        end
        rst = 1'b0;
        sel = 0;
        cyc(4'b0100, 4'b0100, 2, 0, "single_grant");
        repeat (4) cyc(4'b0100, 4'b0100, 2, 0, "single_hold");
        cyc(4'b0000, 4'b0000, 2, 0, "single_release");
        cyc(4'b0000, 4'b0000, 2, 0, "single_idle");
        sel = 1;
        for (int i = 0; i < 4; i++) begin
            repeat (3) cyc(4'hF, 4'(1 << i), i, 0, "rr_grant");
            cyc(4'hF & ~4'(1 << i), 4'h0, i, 0, "rr_gap");
        end
        cyc(4'hF, 4'b0001, 0, 0, "rr_wrap");
        cyc(4'h0, 4'h0, 0, 0, "rr_release");
        cyc(4'h0, 4'h0, 0, 0, "rr_idle");
        sel = 2;
        for (int k = 0; k < 4; k++) begin
            repeat (4) cyc(4'b0011, (k % 2) != 0 ? 4'b0010 : 4'b0001, k % 2, 0, "hold_grant");
            cyc(4'b0011, 4'h0, k % 2, 1, "hold_timeout");
        end
        cyc(4'b0011, 4'b0001, 0, 0, "hold_again");
        cyc(4'h0, 4'h0, 0, 0, "hold_release");
        cyc(4'h0, 4'h0, 0, 0, "hold_idle");
        repeat (4) cyc(4'b0011, 4'b0010, 1, 0, "drop_grant");
        cyc(4'b0001, 4'h0, 1, 0, "drop_at_limit");
        cyc(4'b0001, 4'b0001, 0, 0, "drop_next");
        cyc(4'h0, 4'h0, 0, 0, "drop_release");
        cyc(4'h0, 4'h0, 0, 0, "drop_idle");
        repeat (20) cyc(4'b0001, 4'b0001, 0, 0, "alone_no_timeout");
        cyc(4'h0, 4'h0, 0, 0, "alone_release");
        cyc(4'h0, 4'h0, 0, 0, "alone_idle");
        sel = 3;
        repeat (3) cyc(4'b0010, 4'b0010, 1, 0, "ta3_grant");
        repeat (3) cyc(4'b1000, 4'h0, 1, 0, "ta3_gap");
        cyc(4'b1000, 4'b1000, 3, 0, "ta3_next");
        cyc(4'h0, 4'h0, 3, 0, "ta3_release");
        repeat (3) cyc(4'h0, 4'h0, 3, 0, "ta3_idle");
        sel = 0;
        repeat (2) cyc(4'b0100, 4'b0100, 2, 0, "rst_pre");
        rst = 1'b1;
        cyc(4'b0101, 4'h0, 0, 0, "rst_mid_grant");
        rst = 1'b0;
        repeat (2) cyc(4'b0101, 4'b0001, 0, 0, "rst_after");
        cyc(4'b0100, 4'h0, 0, 0, "rst_release");
        cyc(4'b0100, 4'b0100, 2, 0, "rst_next");
        cyc(4'h0, 4'h0, 2, 0, "rst_end");
        @(negedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
